branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline.
- Replaces the static not-taken policy, where every taken beq/bne flushes IF.
- Sits in IF: looks up the fetch PC in a direct-mapped BTB with saturating counters and supplies a predicted next PC.
- Branch resolution in ID updates the table and reports mispredictions, with a redirect PC.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2; IDX_W = log2(ENTRIES).
- ADDR_W, 32, PC width.
- CNT_W, 2, width of the saturating direction counter; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- if_pc  input  ADDR_W  current fetch PC
- pred_hit  output  1  valid BTB entry whose tag matches if_pc
- pred_taken  output  1  predicted taken
- pred_target  output  ADDR_W  predicted next PC
- upd_valid  input  1  ID stage holds a resolved branch; one-cycle pulse per branch
- upd_pc  input  ADDR_W  PC of the resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  ADDR_W  actual branch target
- upd_pred_taken  input  1  prediction carried with the branch through IF/ID
- upd_pred_target  input  ADDR_W  predicted target carried through IF/ID
- mispredict  output  1  prediction wrong; flush IF/ID
- redirect_pc  output  ADDR_W  correct next PC when mispredict=1

Behaviour:
- Indexing:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - PC bits [1:0] are ignored.
- Per-entry storage: valid, tag, target (ADDR_W), counter (CNT_W).
- Lookup is combinational, with zero latency and the same cycle as if_pc:
  - pred_hit = valid[idx] && tag match
  - pred_taken = pred_hit && counter MSB
  - pred_target = pred_taken ? target[idx] : if_pc+4 (modulo 2^ADDR_W; wrap at all-ones is allowed)
- Update on the rising clk edge when upd_valid=1:
  - Hit, taken: counter increments, saturating at all-ones; target is overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate the entry. Set valid=1, write tag and target, and set counter = weakly taken (MSB=1, other bits 0). This replaces any existing entry at that index.
  - Miss, not taken: no write.
- Mispredict and redirect are combinational from the upd_* inputs:
  - mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target))
  - redirect_pc = upd_taken ? upd_target : upd_pc+4
  - mispredict=0 whenever upd_valid=0.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents (read-old). The new value is visible on the following cycle.
- Caller gating: the caller gates upd_valid with PCWrite. A stalled ID stage must not re-update. The predictor does not detect duplicate updates.
- Reset (asynchronous, rst=0):
  - All valid bits clear; counters = weakly not-taken (MSB=0, other bits 1); targets = 0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - Reset asserted mid-update discards the update. Deassertion is synchronous to clk and handled by the top level.
- No state machine beyond the table. All sequential state lives in the table and the optional counters.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, two outputs are added:
  - stat_branches (32-bit): counts upd_valid cycles.
  - stat_mispredicts (32-bit): counts mispredict cycles.
- Both counters reset to 0 on rst=0 and wrap from 0xFFFFFFFF to 0.
- When undefined, the counters and ports are absent; the core behaviour is identical.

Test Plan:
- Reset, then if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044.
- Update upd_pc=0x40, upd_taken=1, upd_target=0x80, upd_pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x80.
- Taken updates on 0x40 continued 3 times -> counter saturates at 3. Then 2 not-taken updates -> counter=1, pred_taken=0, pred_target=0x44. In the not-taken case with pred_taken=1, expect mispredict=1 and redirect_pc=0x44.
- Aliasing with ENTRIES=16: taken branch at 0x40 allocated, then taken update at 0x80 (same index, different tag) -> lookup 0x40 gives pred_hit=0; lookup 0x80 gives pred_target equal to the new target.
- Same-cycle update and lookup at 0x40 after reset -> lookup shows pred_hit=0 that cycle and pred_hit=1 the next cycle. Not-taken miss update at 0x100 -> lookup 0x100 stays pred_hit=0.
- With BRANCH_PREDICTOR_STATS_EN defined, 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Asserting rst=0 mid-cycle clears both immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the IF stage of the 5-stage MIPS pipeline.
// A direct-mapped branch target buffer (BTB) is looked up combinationally with
// the fetch PC. It supplies a hit flag, a taken prediction and the predicted
// next PC. When a branch resolves in ID, the table is updated on the next
// rising clock edge. The same cycle also reports whether the prediction
// carried through IF/ID was wrong, together with the correct next PC.
//
// Parameters:
//   ENTRIES : number of BTB entries (power of two, >= 2)
//   ADDR_W  : PC width
//   CNT_W   : width of the saturating direction counter (>= 1)
//
// Ports:
//   clk             : rising-edge clock
//   rst             : asynchronous active-low reset
//   if_pc           : fetch PC to look up
//   pred_hit        : valid entry with matching tag for if_pc
//   pred_taken      : predicted taken (hit and counter MSB set)
//   pred_target     : predicted next PC (BTB target or if_pc+4)
//   upd_valid       : one-cycle pulse, ID holds a resolved branch
//   upd_pc          : PC of the resolved branch
//   upd_taken       : actual branch outcome
//   upd_target      : actual branch target
//   upd_pred_taken  : prediction that travelled with the branch
//   upd_pred_target : predicted target that travelled with the branch
//   mispredict      : prediction was wrong, IF/ID must be flushed
//   redirect_pc     : correct next PC, meaningful when mispredict=1
//
// Optional feature (macro BRANCH_PREDICTOR_STATS_EN):
//   stat_branches    : 32-bit wrapping count of upd_valid cycles
//   stat_mispredicts : 32-bit wrapping count of mispredict cycles
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Weakly taken is MSB=1 with the rest clear. Weakly not-taken is the value
    // just below it, i.e. MSB=0 with the rest set. With CNT_W=1 they are 1 and 0.
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_mem  [ENTRIES];
    logic [TAG_W-1:0]  tag_mem    [ENTRIES];
    logic [ADDR_W-1:0] target_mem [ENTRIES];
    logic [CNT_W-1:0]  cnt_mem    [ENTRIES];

    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    // Split both PCs into index and tag. The two low bits are word-offset bits
    // and never take part in the lookup.
    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Zero-latency lookup for the fetch PC. It reads the table as it was before
    // this cycle's update, so a same-index update only shows up next cycle.
    always_comb begin
        pred_hit    = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
        pred_taken  = pred_hit && cnt_mem[if_idx][CNT_W-1];
        pred_target = pred_taken ? target_mem[if_idx] : if_pc + ADDR_W'(4);
    end

    // Resolution check for the branch sitting in ID. A taken branch is also
    // mispredicted when its direction was right but the target was stale.
    always_comb begin
        upd_hit     = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
        mispredict  = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
    end

    // Table update. A hit moves the saturating counter toward the outcome and
    // refreshes the target when taken. A taken miss claims the entry, evicting
    // whatever alias lived there. A not-taken miss is not worth caching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                cnt_mem[i]    <= CNT_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (cnt_mem[upd_idx] != CNT_MAX) begin
                        cnt_mem[upd_idx] <= cnt_mem[upd_idx] + CNT_W'(1);
                    end
                    target_mem[upd_idx] <= upd_target;
                end else if (cnt_mem[upd_idx] != '0) begin
                    cnt_mem[upd_idx] <= cnt_mem[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_mem[upd_idx]  <= 1'b1;
                tag_mem[upd_idx]    <= upd_tag;
                target_mem[upd_idx] <= upd_target;
                cnt_mem[upd_idx]    <= CNT_WT;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    // Free-running event counters for performance analysis. They wrap silently
    // at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    // Without statistics, the predictor is just the table and its
    // combinational paths.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. It uses a behavioural model of the
// BTB: per-entry valid/tag/target, with the direction counter held as a plain
// integer that saturates between 0 and 2^CNT_W-1. Directed scenarios are
// followed by a long randomized run. When BRANCH_PREDICTOR_STATS_EN is defined,
// the statistics counters are checked as well.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int WT      = 1 << (CNT_W - 1);

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    int total;
    int bad;

    // Reference model state.
    bit          m_valid  [ENTRIES];
    bit [31:0]   m_tag    [ENTRIES];
    bit [31:0]   m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int unsigned exp_branches;
    int unsigned exp_mis;

    branch_predictor #(
        .ENTRIES(ENTRIES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit [31:0] tag_of(input bit [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_ptaken(input bit [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= WT);
    endfunction

    function automatic bit [31:0] m_ptarget(input bit [31:0] pc);
        return m_ptaken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis(input bit v, input bit t, input bit [31:0] tgt,
                                 input bit pt, input bit [31:0] ptgt);
        return v && ((pt != t) || (t && (ptgt != tgt)));
    endfunction

    function automatic bit [31:0] m_redirect(input bit [31:0] pc, input bit t,
                                             input bit [31:0] tgt);
        return t ? tgt : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_cnt[i]    = WT - 1;
        end
        exp_branches = 0;
        exp_mis      = 0;
    endtask

    task automatic model_update(input bit [31:0] pc, input bit t, input bit [31:0] tgt);
        int i;
        i = idx_of(pc);
        if (m_hit(pc)) begin
            if (t) begin
                m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_target[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (t) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(pc);
            m_target[i] = tgt;
            m_cnt[i]    = WT;
        end
    endtask

    // Advance one clock: the model sees the same inputs the DUT samples at the
    // rising edge, then control returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (upd_valid) begin
            exp_branches++;
            if (m_mis(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target))
                exp_mis++;
            model_update(upd_pc, upd_taken, upd_target);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_update(input bit v, input bit [31:0] pc, input bit t,
                              input bit [31:0] tgt, input bit pt, input bit [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        if_pc = 32'h0000_0040;
        #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_hit got=%b want=0", pred_hit);
        end
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_taken got=%b want=0", pred_taken);
        end
        total++;
        if (pred_target !== 32'h0000_0044) begin
            bad++; $display("[TB] FAIL reset_target got=%h want=00000044", pred_target);
        end
        total++;
        if (mispredict !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_mispredict got=%b want=0", mispredict);
        end
    endtask

    task automatic test_allocate_and_saturate();
        if_pc = 32'h40;
        set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++; $display("[TB] FAIL alloc_mispredict got=%b want=1", mispredict);
        end
        total++;
        if (redirect_pc !== 32'h80) begin
            bad++; $display("[TB] FAIL alloc_redirect got=%h want=00000080", redirect_pc);
        end
        tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h80) begin
            bad++; $display("[TB] FAIL alloc_lookup got=%b%b/%h want=11/00000080",
                            pred_hit, pred_taken, pred_target);
        end
        // Three more taken updates with correct prediction: counter saturates.
        for (int k = 0; k < 3; k++) begin
            set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            total++;
            if (mispredict !== 1'b0) begin
                bad++; $display("[TB] FAIL sat_mispredict[%0d] got=%b want=0", k, mispredict);
            end
            tick();
        end
        total++;
        if (m_cnt[idx_of(32'h40)] != CMAX || pred_taken !== 1'b1) begin
            bad++; $display("[TB] FAIL sat_taken got=%b want=1", pred_taken);
        end
        // First not-taken while predicted taken: mispredict, fall through.
        set_update(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        total++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h44) begin
            bad++; $display("[TB] FAIL nt_mispredict got=%b/%h want=1/00000044",
                            mispredict, redirect_pc);
        end
        tick();
        // Counter 2 still predicts taken.
        total++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            bad++; $display("[TB] FAIL nt_once got=%b/%h want=1/00000080", pred_taken, pred_target);
        end
        tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h44) begin
            bad++; $display("[TB] FAIL nt_twice got=%b%b/%h want=10/00000044",
                            pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        do_reset();
        set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        tick();
        set_update(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
        tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h40;
        #1;
        total++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h44) begin
            bad++; $display("[TB] FAIL alias_old got=%b/%h want=0/00000044", pred_hit, pred_target);
        end
        if_pc = 32'h80;
        #1;
        total++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h300) begin
            bad++; $display("[TB] FAIL alias_new got=%b/%h want=1/00000300", pred_hit, pred_target);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        if_pc = 32'h40;
        set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("[TB] FAIL same_cycle_old got=%b want=0", pred_hit);
        end
        tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        total++;
        if (pred_hit !== 1'b1) begin
            bad++; $display("[TB] FAIL same_cycle_new got=%b want=1", pred_hit);
        end
        // A not-taken miss must not allocate.
        set_update(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        #1;
        total++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h104) begin
            bad++; $display("[TB] FAIL nt_miss_resolve got=%b/%h want=0/00000104",
                            mispredict, redirect_pc);
        end
        tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h100;
        #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("[TB] FAIL nt_miss_alloc got=%b want=0", pred_hit);
        end
        // Fall-through wraps at the top of the address space.
        if_pc = 32'hFFFF_FFFC;
        #1;
        total++;
        if (pred_target !== 32'h0) begin
            bad++; $display("[TB] FAIL wrap_target got=%h want=00000000", pred_target);
        end
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        set_update(1'b1, 32'h48, 1'b1, 32'h90, 1'b0, 32'h4C);
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h48;
        #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_discard got=%b want=0", pred_hit);
        end
    endtask

    task automatic test_back_to_back();
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ptgt;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            pt   = m_ptaken(pc);
            ptgt = m_ptarget(pc);
            if ($urandom_range(0, 4) == 0) pt = ~pt;
            if ($urandom_range(0, 4) == 0) ptgt = {$urandom_range(0, 255), 2'b00};
            set_update($urandom_range(0, 9) < 7, pc, $urandom_range(0, 1) == 1,
                       {$urandom_range(0, 255), 2'b00}, pt, ptgt);
            if_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                    $urandom_range(0, 3);
            #1;
            total++;
            if (pred_hit !== m_hit(if_pc) || pred_taken !== m_ptaken(if_pc) ||
                pred_target !== m_ptarget(if_pc)) begin
                bad++;
                $display("[TB] FAIL rand_lookup pc=%h got=%b%b/%h want=%b%b/%h", if_pc,
                         pred_hit, pred_taken, pred_target,
                         m_hit(if_pc), m_ptaken(if_pc), m_ptarget(if_pc));
            end
            total++;
            if (mispredict !== m_mis(upd_valid, upd_taken, upd_target, upd_pred_taken,
                                     upd_pred_target) ||
                redirect_pc !== m_redirect(upd_pc, upd_taken, upd_target)) begin
                bad++;
                $display("[TB] FAIL rand_resolve got=%b/%h want=%b/%h", mispredict, redirect_pc,
                         m_mis(upd_valid, upd_taken, upd_target, upd_pred_taken,
                               upd_pred_target),
                         m_redirect(upd_pc, upd_taken, upd_target));
            end
            tick();
        end
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef BRANCH_PREDICTOR_STATS_EN
        total++;
        if (stat_branches !== exp_branches || stat_mispredicts !== exp_mis) begin
            bad++;
            $display("[TB] FAIL rand_stats got=%0d/%0d want=%0d/%0d",
                     stat_branches, stat_mispredicts, exp_branches, exp_mis);
        end
`endif
    endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
    task automatic test_stats();
        do_reset();
        set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44); tick();  // mispredict
        set_update(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80); tick();
        set_update(1'b1, 32'h50, 1'b0, 32'h90, 1'b0, 32'h54); tick();
        set_update(1'b1, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80); tick();  // wrong target
        set_update(1'b1, 32'h60, 1'b0, 32'h90, 1'b0, 32'h64); tick();
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        total++;
        if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            bad++; $display("[TB] FAIL stats_count got=%0d/%0d want=5/2",
                            stat_branches, stat_mispredicts);
        end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            bad++; $display("[TB] FAIL stats_reset got=%0d/%0d want=0/0",
                            stat_branches, stat_mispredicts);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    // Directed scenarios first, then the randomized back-to-back run.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        if_pc = 32'h0;
        set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        test_reset();
        test_allocate_and_saturate();
        test_alias();
        test_same_cycle();
        test_reset_mid_update();
`ifdef BRANCH_PREDICTOR_STATS_EN
        test_stats();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
